// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package prog_loader_pkg;

    localparam int unsigned PL_ADDR_W      = 4;
    localparam int unsigned PL_DATA_W      = 8;
    localparam int unsigned PL_SYNC_STAGES = 2;
    localparam int unsigned DEPTH          = 1 << PL_ADDR_W;

    localparam logic [7:0] CKSUM_SEED = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } state_e;

endpackage : prog_loader_pkg

// File: rtl/prog_loader_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin plus a one-cycle rising-edge pulse.
module prog_loader_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_c_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the synchronizer chain and remember the last synced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o  = sync_q[SYNC_STAGES-1];
    assign rise_c_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : prog_loader_pin_sync

// File: rtl/prog_loader.sv
// Loads the CPU instruction memory from slow async pins, verifies an XOR checksum,
// and holds the CPU in reset until a load verifies.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = PL_ADDR_W,
    parameter int unsigned DATA_W      = PL_DATA_W,
    parameter int unsigned SYNC_STAGES = PL_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req_i,
    input  logic              load_strobe_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic [DATA_W-1:0] fetch_instr_o,
    output logic              cpu_rst_n_o,
    output logic              load_busy_o,
    output logic              load_err_o,
    output logic [ADDR_W:0]   byte_count_o
);

    localparam int unsigned MEM_DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W     = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   cksum_q, cksum_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                mem_we_c;
    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

    logic req_lvl, req_rise, stb_rise;
    logic stb_lvl_unused;

    prog_loader_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_i  (load_req_i),
        .level_o  (req_lvl),
        .rise_c_o (req_rise)
    );

    prog_loader_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_i  (load_strobe_i),
        .level_o  (stb_lvl_unused),
        .rise_c_o (stb_rise)
    );

    // Next-state, counter, checksum and write-enable logic; abort beats a same-cycle strobe.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        cksum_d  = cksum_q;
        mem_we_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_lvl) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    cksum_d = DATA_W'(CKSUM_SEED);
                end
            end
            ST_LOAD: begin
                if (!req_lvl) begin
                    state_d = ST_ERROR;
                end else if (stb_rise) begin
                    mem_we_c = 1'b1;
                    cksum_d  = cksum_q ^ load_data_i;
                    count_d  = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(MEM_DEPTH - 1)) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!req_lvl) begin
                    state_d = ST_ERROR;
                end else if (stb_rise) begin
                    state_d = (load_data_i == cksum_q) ? ST_RUN : ST_ERROR;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (req_rise) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    cksum_d = DATA_W'(CKSUM_SEED);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        err_d       = (state_d == ST_ERROR);
        cpu_rst_n_d = (state_q == ST_RUN);
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            cksum_q     <= DATA_W'(CKSUM_SEED);
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cksum_q     <= cksum_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Instruction memory; cleared by reset, written one byte per accepted strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we_c) begin
            mem_q[count_q[ADDR_W-1:0]] <= load_data_i;
        end
    end

    assign fetch_instr_o = mem_q[fetch_addr_i];
    assign cpu_rst_n_o   = cpu_rst_n_q;
    assign load_busy_o   = busy_q;
    assign load_err_o    = err_q;
    assign byte_count_o  = count_q;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic       load_req;
    logic       load_strobe;
    logic [7:0] load_data;
    logic [3:0] fetch_addr;
    logic [7:0] fetch_instr;
    logic       cpu_rst_n;
    logic       load_busy;
    logic       load_err;
    logic [4:0] byte_count;

    int vecs;
    int miss;

    prog_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_req_i    (load_req),
        .load_strobe_i (load_strobe),
        .load_data_i   (load_data),
        .fetch_addr_i  (fetch_addr),
        .fetch_instr_o (fetch_instr),
        .cpu_rst_n_o   (cpu_rst_n),
        .load_busy_o   (load_busy),
        .load_err_o    (load_err),
        .byte_count_o  (byte_count)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag, input int addr, input logic [7:0] exp);
        fetch_addr = 4'(addr);
        #1;
        check(tag, 32'(fetch_instr), 32'(exp));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        load_data = b;
        @(negedge clk);
        load_strobe = 1'b1;
        repeat (5) @(negedge clk);
        load_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vecs        = 0;
        miss        = 0;
        clk_en      = 1'b0;
        rst_n       = 1'b1;
        load_req    = 1'b0;
        load_strobe = 1'b0;
        load_data   = 8'h00;
        fetch_addr  = 4'h0;

        // Reset with the clock stopped
        #2 rst_n = 1'b0;
        #1;
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_busy", 32'(load_busy), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_count", 32'(byte_count), 32'd0);
        for (int a = 0; a < 16; a++) check_mem("rst_mem", a, 8'h00);

        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Strobe in IDLE is ignored
        send_byte(8'h77);
        check("idle_stb_count", 32'(byte_count), 32'd0);
        check("idle_stb_busy", 32'(load_busy), 32'd0);
        check_mem("idle_stb_mem0", 0, 8'h00);

        // Good load: 0x10..0x1F, checksum 0x00
        load_req = 1'b1;
        repeat (4) @(negedge clk);
        check("load_busy", 32'(load_busy), 32'd1);
        check("load_cpu_rst", 32'(cpu_rst_n), 32'd0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
        check("full_count", 32'(byte_count), 32'd16);
        check("check_busy", 32'(load_busy), 32'd1);
        send_byte(8'h00);
        check("run_cpu_rst", 32'(cpu_rst_n), 32'd1);
        check("run_busy", 32'(load_busy), 32'd0);
        check("run_err", 32'(load_err), 32'd0);
        check_mem("run_mem5", 5, 8'h15);
        check_mem("run_mem15", 15, 8'h1F);

        // Strobes in RUN are ignored
        send_byte(8'hEE);
        check("run_stb_count", 32'(byte_count), 32'd16);
        check("run_stb_cpu", 32'(cpu_rst_n), 32'd1);
        check_mem("run_stb_mem0", 0, 8'h10);

        // Reload from RUN, then abort after 7 bytes with a simultaneous strobe
        @(negedge clk);
        load_req = 1'b0;
        repeat (4) @(negedge clk);
        load_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reload_cpu_rst", 32'(cpu_rst_n), 32'd0);
        check("reload_busy", 32'(load_busy), 32'd1);
        check("reload_count", 32'(byte_count), 32'd0);
        for (int i = 0; i < 7; i++) send_byte(8'(8'hA0 + i));
        check("part_count", 32'(byte_count), 32'd7);
        @(negedge clk);
        load_data = 8'h55;
        @(negedge clk);
        load_req    = 1'b0;
        load_strobe = 1'b1;
        repeat (5) @(negedge clk);
        load_strobe = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_err", 32'(load_err), 32'd1);
        check("abort_busy", 32'(load_busy), 32'd0);
        check("abort_cpu", 32'(cpu_rst_n), 32'd0);
        check("abort_count", 32'(byte_count), 32'd7);
        for (int a = 0; a < 7; a++) check_mem("abort_mem_new", a, 8'(8'hA0 + a));
        check_mem("abort_mem7", 7, 8'h17);

        // From ERROR, reload with a bad checksum
        load_req = 1'b1;
        repeat (4) @(negedge clk);
        check("err_reload_err", 32'(load_err), 32'd0);
        check("err_reload_busy", 32'(load_busy), 32'd1);
        check("err_reload_count", 32'(byte_count), 32'd0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
        check("bad_full_count", 32'(byte_count), 32'd16);
        send_byte(8'hFF);
        check("bad_err", 32'(load_err), 32'd1);
        check("bad_cpu", 32'(cpu_rst_n), 32'd0);
        check("bad_busy", 32'(load_busy), 32'd0);
        check("bad_count", 32'(byte_count), 32'd16);
        check_mem("bad_mem0", 0, 8'h10);
        check_mem("bad_mem7", 7, 8'h17);
        check_mem("bad_mem15", 15, 8'h1F);

        // Async reset in the middle of a load
        @(negedge clk);
        load_req = 1'b0;
        repeat (4) @(negedge clk);
        load_req = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i));
        check("mid_count", 32'(byte_count), 32'd4);
        check_mem("mid_mem3", 3, 8'h34);
        @(negedge clk);
        clk_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(load_busy), 32'd0);
        check("arst_count", 32'(byte_count), 32'd0);
        check("arst_err", 32'(load_err), 32'd0);
        check("arst_cpu", 32'(cpu_rst_n), 32'd0);
        for (int a = 0; a < 16; a++) check_mem("arst_mem", a, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule : tb_prog_loader
